// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot anti-ghost blanking
// and frame-synchronous double buffering of the displayed value.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        load,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_dig;
    logic [15:0]        r_act_data;
    logic [3:0]         r_act_dp;
    logic [3:0]         r_act_blank;
    logic [15:0]        r_pend_data;
    logic [3:0]         r_pend_dp;
    logic [3:0]         r_pend_blank;
    logic               r_pend_vld;
    logic [7:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_frame;

    logic               w_wrap;
    logic               w_frame_end;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic               w_blank;
    logic [3:0]         w_an_drv;

    function automatic logic [6:0] f_seg7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_wrap      = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_wrap && (r_dig == 2'd3);
    assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
    assign w_nib       = r_act_data[{r_dig, 2'b00} +: 4];
    assign w_dp        = r_act_dp[r_dig];
    assign w_blank     = r_act_blank[r_dig];
    assign w_an_drv    = ~(4'b0001 << r_dig);

    // Scan timing, slot phase FSM, output registers and the pending/active buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_dig        <= 2'd0;
            r_act_data   <= 16'h0000;
            r_act_dp     <= 4'h0;
            r_act_blank  <= 4'h0;
            r_pend_data  <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_blank <= 4'h0;
            r_pend_vld   <= 1'b0;
            r_seg        <= 8'hFF;
            r_an         <= 4'hF;
            r_frame      <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_end;
            if (w_wrap) begin
                r_dig <= r_dig + 2'd1;
            end

            // Phase tracks the counter value being loaded, so it always matches r_cnt
            if (w_wrap || (w_cnt_nxt < CNT_W'(BLANK_CYC))) begin
                r_state <= ST_BLANK;
            end else begin
                r_state <= ST_DRIVE;
            end

            if ((r_state == ST_DRIVE) && !w_blank) begin
                r_an  <= w_an_drv;
                r_seg <= {~w_dp, f_seg7(w_nib)};
            end else begin
                r_an  <= 4'hF;
                r_seg <= 8'hFF;
            end

            // Active set only changes at the frame boundary, so a frame never tears
            if (w_frame_end && r_pend_vld) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end

            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp;
                r_pend_blank <= blank;
                r_pend_vld   <= 1'b1;
            end else if (w_frame_end) begin
                r_pend_vld   <= 1'b0;
            end
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000; clock cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 1000; anti-ghost cycles per slot with all anodes off; legal range 1..SCAN_DIV-2.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data  input  16  four hex nibbles; digit k shows data[4k+3:4k]; digit 0 is rightmost.
REQ-006 SHALL have port dp  input  4  decimal point request per digit; 1 = lit.
REQ-007 SHALL have port blank  input  4  per-digit blank request; 1 = digit dark.
REQ-008 SHALL have port load  input  1  single-cycle strobe capturing data/dp/blank into the pending register.
REQ-009 SHALL have port seg  output  8  cathodes {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an  output  4  anodes, an[k] drives digit k, active-low.
REQ-011 SHALL have port frame  output  1  one-cycle pulse when a full four-digit frame completes.

Function
REQ-012 SHALL keep slot counter cnt, 0..SCAN_DIV-1, incrementing every cycle; wraps to 0 after SCAN_DIV-1.
REQ-013 SHALL keep digit index dig, 0..3; advances by 1 when cnt wraps; 3 wraps to 0.
REQ-014 SHALL implement FSM per slot: BLANK (cnt < BLANK_CYC, an = 4'hF, seg = 8'hFF) -> DRIVE (cnt >= BLANK_CYC) -> BLANK of next slot on wrap.
REQ-015 SHALL in DRIVE assert only an[dig] low, unless blank[dig] of the active set is 1, in which case an = 4'hF.
REQ-016 SHALL register seg and an; outputs reflect cnt/dig state with exactly one cycle latency.
REQ-017 SHALL on load = 1 capture data, dp, blank into pending and set pending-valid flag.
REQ-018 SHALL transfer pending to active set only at frame boundary (cnt wrap while dig = 3), then clear pending-valid; no tearing within a frame.
REQ-019 SHALL give load priority when load coincides with frame boundary: new value captured to pending and pending-valid stays set; previous pending value goes to active.
REQ-020 SHALL let the later load overwrite pending when several loads occur in one frame (last-write-wins).
REQ-021 SHALL pulse frame high for exactly one cycle, the cycle after each frame boundary.
REQ-022 SHALL decode nibble to seg[6:0] (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, bit 7 excluded).
REQ-023 SHALL drive seg[7] = ~dp[dig] of the active set in DRIVE.
REQ-024 SHALL ignore data/dp/blank changes when load = 0.

Reset
REQ-025 SHALL on rst_n = 0, immediately and regardless of clk: seg = 8'hFF, an = 4'hF, frame = 0, cnt = 0, dig = 0, active and pending sets = 0, pending-valid = 0.
REQ-026 SHALL restart at slot 0 BLANK on first rising clk after rst_n deasserts; reset mid-slot or mid-frame discards pending value.
REQ-027 SHALL show "0000" with no dp after reset until a load reaches the active set.

Verification
REQ-028 SHALL verify, SCAN_DIV=8, BLANK_CYC=2: after reset, an sequence per slot = F,F,E×6 then F,F,D×6, F,F,B×6, F,F,7×6; seg = C0 during DRIVE.
REQ-029 SHALL verify load data=16'h12AF, dp=4'b0100 mid-frame -> display unchanged until frame pulse; next frame shows seg 8E, 88, 24, F9 for digits 0..3 (digit 2 = 24).
REQ-030 SHALL verify blank=4'b1001 loaded -> digits 0 and 3 slots keep an = F whole slot; digits 1, 2 driven normally.
REQ-031 SHALL verify load asserted in the frame-boundary cycle with 16'hBEEF while pending 16'h1111 -> next frame shows 1111, following frame shows BEEF.
REQ-032 SHALL verify rst_n pulled low mid-DRIVE (asynchronously, between clk edges) -> an = F, seg = FF within same cycle; after release, scan restarts at digit 0 showing 0000.
REQ-033 SHALL verify frame pulse width = 1 cycle, period = 4*SCAN_DIV cycles (32 with test parameters).
